morph_win_ctrl: RTL and testbench

- Frame-level sequencer for the 3x3 binary morphology kernel (erosion/dilation, 3-bit row inputs q1/q2/q3 plus sel).
- Accepts a raster stream of 1-bit pixels, buffers three image rows, and presents one 3x3 window per output beat through a valid/ready handshake, one window per pixel.
- Inserts border padding and latches the operation mode for the whole frame.
- Sits between the pixel source and the combinational kernel.

---
 rtl/morph_win_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_morph_win_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/morph_win_ctrl.sv
// Frame sequencer for the 3x3 binary morphology kernel: buffers three rows of a
// 1-bit raster stream and presents one padded 3x3 window per pixel over valid/ready.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for start; mode latched and row buffers padded on start
// LOAD  | accepting one input row into new; shifts the row window when full
// SCAN  | presenting windows for the current centre row, one per column
// FLUSH | one cycle: shift in a pad row so the last image row can be centred
// DONE  | one-cycle done pulse, then back to IDLE
module morph_win_ctrl #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       sel_in,
    input  logic                       pix_in,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    output logic [2:0]                 q1,
    output logic [2:0]                 q2,
    output logic [2:0]                 q3,
    output logic                       sel,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [$clog2(HEIGHT)-1:0]  win_row,
    output logic [$clog2(WIDTH)-1:0]   win_col,
    output logic                       busy,
    output logic                       done
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int NW = $clog2(HEIGHT + 1);
    localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);
    localparam logic [NW-1:0] ROWS     = NW'(HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t           state_q;
    logic             sel_q;
    logic             pix_ready_q;
    logic             win_valid_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] top_q;
    logic [WIDTH-1:0] mid_q;
    logic [WIDTH-1:0] bot_q;
    logic [WIDTH-1:0] new_q;
    logic [WIDTH-1:0] new_d;
    logic [CW-1:0]    col_q;
    logic [NW-1:0]    row_cnt_q;
    logic [RW-1:0]    cen_q;

    logic             pix_acc;
    logic             win_acc;
    logic [CW:0]      ci;
    logic [WIDTH+1:0] ext_top;
    logic [WIDTH+1:0] ext_mid;
    logic [WIDTH+1:0] ext_bot;

    assign pix_acc = pix_valid & pix_ready_q;
    assign win_acc = win_valid_q & win_ready;

    // The final pixel of a row must reach bot in the same cycle it is accepted.
    always_comb begin
        new_d        = new_q;
        new_d[col_q] = pix_in;
    end

    // Pad on both ends so column -1 and column WIDTH read the neutral element.
    always_comb begin
        ci      = {1'b0, col_q};
        ext_top = {sel_q, top_q, sel_q};
        ext_mid = {sel_q, mid_q, sel_q};
        ext_bot = {sel_q, bot_q, sel_q};
        q1      = {ext_top[ci], ext_top[ci + 1'b1], ext_top[ci + 2'd2]};
        q2      = {ext_mid[ci], ext_mid[ci + 1'b1], ext_mid[ci + 2'd2]};
        q3      = {ext_bot[ci], ext_bot[ci + 1'b1], ext_bot[ci + 2'd2]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sel_q       <= 1'b0;
            pix_ready_q <= 1'b0;
            win_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            top_q       <= '0;
            mid_q       <= '0;
            bot_q       <= '0;
            new_q       <= '0;
            col_q       <= '0;
            row_cnt_q   <= '0;
            cen_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sel_q       <= sel_in;
                        top_q       <= {WIDTH{sel_in}};
                        mid_q       <= {WIDTH{sel_in}};
                        bot_q       <= {WIDTH{sel_in}};
                        col_q       <= '0;
                        row_cnt_q   <= '0;
                        cen_q       <= '0;
                        busy_q      <= 1'b1;
                        pix_ready_q <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (pix_acc) begin
                        new_q <= new_d;
                        if (col_q == LAST_COL) begin
                            col_q     <= '0;
                            top_q     <= mid_q;
                            mid_q     <= bot_q;
                            bot_q     <= new_d;
                            row_cnt_q <= row_cnt_q + 1'b1;
                            // With only one row in hand there is no centre row yet.
                            if (row_cnt_q != '0) begin
                                cen_q       <= RW'(row_cnt_q - 1'b1);
                                pix_ready_q <= 1'b0;
                                win_valid_q <= 1'b1;
                                state_q     <= S_SCAN;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end

                S_SCAN: begin
                    if (win_acc) begin
                        if (col_q == LAST_COL) begin
                            col_q       <= '0;
                            win_valid_q <= 1'b0;
                            if (cen_q == LAST_ROW) begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else if (row_cnt_q < ROWS) begin
                                pix_ready_q <= 1'b1;
                                state_q     <= S_LOAD;
                            end else begin
                                state_q <= S_FLUSH;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end

                S_FLUSH: begin
                    top_q       <= mid_q;
                    mid_q       <= bot_q;
                    bot_q       <= {WIDTH{sel_q}};
                    cen_q       <= LAST_ROW;
                    win_valid_q <= 1'b1;
                    state_q     <= S_SCAN;
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    pix_ready_q <= 1'b0;
                    win_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign pix_ready = pix_ready_q;
    assign win_valid = win_valid_q;
    assign sel       = sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign win_row   = cen_q;
    assign win_col   = col_q;

endmodule

// File: tb/tb_morph_win_ctrl.sv
// Directed bench for morph_win_ctrl on a 4x3 frame: padding, stalls, gapped input,
// start-while-busy and mid-frame reset.
module tb_morph_win_ctrl;

    localparam int W = 4;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sel_in = 1'b0;
    logic       pix_in = 1'b0;
    logic       pix_valid = 1'b0;
    logic       win_ready = 1'b0;
    logic       pix_ready;
    logic       sel;
    logic       win_valid;
    logic       busy;
    logic       done;
    logic [2:0] q1;
    logic [2:0] q2;
    logic [2:0] q3;
    logic [1:0] win_row;
    logic [1:0] win_col;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] cap_bits [16];
    int         cap_row  [16];
    int         cap_col  [16];
    int         n_win, n_done, pidx, sel_bad, overlap, stall_cnt, stall_chg;

    morph_win_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sel_in    (sel_in),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .q1        (q1),
        .q2        (q2),
        .q3        (q3),
        .sel       (sel),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_row   (win_row),
        .win_col   (win_col),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {14'd0, pix_ready, q1, q2, q3, sel, win_valid, win_row, win_col, busy, done};
    endfunction

    function automatic bit px(input bit s, input logic [11:0] img, input int r, input int c);
        if (r < 0 || r >= H || c < 0 || c >= W) return s;
        return img[r*W + c];
    endfunction

    function automatic logic [8:0] exp_win(input bit s, input logic [11:0] img, input int r, input int c);
        logic [8:0] v;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                v[8 - (dr*3 + dc)] = px(s, img, r - 1 + dr, c - 1 + dc);
        return v;
    endfunction

    // Runs one frame; all driving and sampling happens on the falling edge.
    task automatic run_frame(input bit s, input logic [11:0] img, input bit tog,
                             input bit stall, input bit spam, input bit abort);
        logic [3:0]  vpat;
        logic [12:0] snap;
        logic [12:0] cur;
        int          post, first_wv, acc8;
        bit          aborted;
        vpat = 4'b1001;
        n_win = 0; n_done = 0; pidx = 0; sel_bad = 0; overlap = 0;
        stall_cnt = 0; stall_chg = 0; snap = '0;
        post = -1; first_wv = -1; acc8 = -1; aborted = 0;
        for (int i = 0; i < 16; i++) begin
            cap_bits[i] = '0; cap_row[i] = -1; cap_col[i] = -1;
        end
        @(negedge clk);
        sel_in = s;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (done) begin
                n_done++;
                if (post < 0) post = 3;
            end
            if (busy && sel !== s) sel_bad++;
            if (pix_ready && win_valid) overlap++;
            if (win_valid && first_wv < 0) first_wv = cyc;
            pix_valid = (pidx < W*H) && (!tog || vpat[cyc % 4]);
            pix_in    = (pidx < W*H) ? img[pidx] : 1'b0;
            if (pix_ready && pix_valid) begin
                pidx++;
                if (pidx == 2*W) acc8 = cyc;
            end
            win_ready = 1'b1;
            cur = {q1, q2, q3, win_row, win_col};
            if (stall && win_valid && win_row == 2'd1 && win_col == 2'd2 && stall_cnt < 5) begin
                win_ready = 1'b0;
                if (stall_cnt == 0) snap = cur;
                else if (cur !== snap) stall_chg++;
                stall_cnt++;
            end
            if (win_valid && win_ready) begin
                if (n_win < 16) begin
                    cap_bits[n_win] = {q1, q2, q3};
                    cap_row[n_win]  = int'(win_row);
                    cap_col[n_win]  = int'(win_col);
                end
                n_win++;
            end
            start = spam && busy && (cyc % 7 == 3);
            if (abort && win_valid && win_row == 2'd1) begin
                aborted = 1;
                break;
            end
            if (post == 0) break;
            if (post > 0) post--;
            @(negedge clk);
        end
        pix_valid = 1'b0;
        start     = 1'b0;
        win_ready = 1'b0;
        if (aborted) begin
            rst_n = 1'b0;
            #1;
            chk("abort_outs", outs(), 32'd0);
            repeat (2) begin
                @(negedge clk);
                chk("abort_in_rst", {busy, done, pix_ready, win_valid}, 32'd0);
            end
            rst_n = 1'b1;
            repeat (2) begin
                @(negedge clk);
                chk("abort_after", {busy, done, pix_ready, win_valid}, 32'd0);
            end
            return;
        end
        if (post < 0) chk("frame_timeout", 32'd0, 32'd1);
        chk("n_windows", n_win, W*H);
        chk("n_done", n_done, 1);
        chk("n_pixels", pidx, W*H);
        chk("sel_held", sel_bad, 0);
        chk("ready_overlap", overlap, 0);
        for (int i = 0; i < W*H && i < n_win; i++) begin
            chk($sformatf("pos%0d", i), cap_row[i]*W + cap_col[i], i);
            chk($sformatf("win%0d", i), cap_bits[i], exp_win(s, img, i / W, i % W));
        end
        if (!tog && !stall) chk("first_win_lat", first_wv - acc8, 1);
    endtask

    initial begin
        int idle_bad;
        int nz;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", outs(), 32'd0);
        rst_n = 1'b1;
        idle_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || done || pix_ready || win_valid) idle_bad++;
        end
        chk("idle_quiet", idle_bad, 0);

        // single pixel at (1,1), dilation
        run_frame(1'b0, 12'h020, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_w00", cap_bits[0], 9'b000_000_001);
        chk("t2_w11", cap_bits[5], 9'b000_010_000);
        nz = 0;
        for (int i = 0; i < W*H; i++) if (cap_bits[i] != 9'd0) nz++;
        chk("t2_nonzero", nz, 9);

        // all ones, erosion: border pads with ones
        run_frame(1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_w00", cap_bits[0], 9'h1FF);
        chk("t3_w23", cap_bits[11], 9'h1FF);

        // consumer stall at window (1,2)
        run_frame(1'b0, 12'h5A3, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("stall_len", stall_cnt, 5);
        chk("stall_stable", stall_chg, 0);
        chk("after_stall", cap_row[7]*W + cap_col[7], 7);

        // gapped input and start pulses while busy
        run_frame(1'b0, 12'h5A3, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t5_w11", cap_bits[5], 9'b110_010_101);
        chk("t5_w23", cap_bits[11], 9'b010_100_000);

        // reset during centre row 1, then a clean all-zero frame
        run_frame(1'b0, 12'h5A3, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
